// File: rtl/commit_store_buffer_pkg.sv
// Shared types and sizing for the commit store buffer and its forwarding matcher.
package commit_store_buffer_pkg;

   localparam int unsigned sb_depth = 8;
   localparam int unsigned ADDR_W   = 20;
   localparam int unsigned DATA_W   = 32;

   typedef logic [ADDR_W-1:0] pptr_t;
   typedef logic [DATA_W-1:0] word_t;

   typedef struct packed {
      pptr_t addr;
      word_t data;
      logic  isbyte;
   } sb_entry_t;

   // Extract byte lane `lane` of a word, zero-extended into [7:0].
   function automatic word_t lane_byte(input word_t w, input logic [1:0] lane);
      word_t r;
      r = '0;
      case (lane)
         2'd0: r[7:0] = w[7:0];
         2'd1: r[7:0] = w[15:8];
         2'd2: r[7:0] = w[23:16];
         default: r[7:0] = w[31:24];
      endcase
      return r;
   endfunction

endpackage

// File: rtl/commit_store_buffer_fwd.sv
// Youngest-first store-to-load forwarding match over the occupied buffer entries.
module sb_forward_match
   import commit_store_buffer_pkg::*;
#(
   parameter int unsigned DEPTH = sb_depth,
   parameter int unsigned PTR_W = $clog2(DEPTH)
) (
   input  sb_entry_t        entries_i [DEPTH],
   input  logic [PTR_W-1:0] head_i,
   input  logic [PTR_W:0]   count_i,
   input  pptr_t            lookup_addr_i,
   input  logic             lookup_isbyte_i,
   output logic             hit_o,
   output word_t            data_o,
   output logic             conflict_o
);

   logic [PTR_W-1:0] idx;
   sb_entry_t        ent;

   // Walk oldest to youngest so the youngest overlapping entry decides the result.
   always_comb begin
      hit_o      = 1'b0;
      data_o     = '0;
      conflict_o = 1'b0;
      idx        = '0;
      ent        = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         idx = head_i + PTR_W'(i);
         ent = entries_i[idx];
         if (((PTR_W+1)'(i) < count_i) && (ent.addr[ADDR_W-1:2] == lookup_addr_i[ADDR_W-1:2])) begin
            if (ent.isbyte && !lookup_isbyte_i) begin
               hit_o      = 1'b0;
               data_o     = '0;
               conflict_o = 1'b1;
            end else if (!ent.isbyte && !lookup_isbyte_i) begin
               hit_o      = 1'b1;
               data_o     = ent.data;
               conflict_o = 1'b0;
            end else if (!ent.isbyte) begin
               hit_o      = 1'b1;
               data_o     = lane_byte(ent.data, lookup_addr_i[1:0]);
               conflict_o = 1'b0;
            end else if (ent.addr[1:0] == lookup_addr_i[1:0]) begin
               hit_o      = 1'b1;
               data_o     = {24'b0, ent.data[7:0]};
               conflict_o = 1'b0;
            end
         end
      end
   end

endmodule

// File: rtl/commit_store_buffer.sv
// In-order buffer of committed stores, drained to the d-cache, with load forwarding.
module commit_store_buffer
   import commit_store_buffer_pkg::*;
#(
   parameter int unsigned DEPTH = sb_depth,
   parameter int unsigned PTR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              store_en,
   input  logic              store_isbyte,
   input  logic [ADDR_W-1:0] store_addr,
   input  logic [DATA_W-1:0] store_data,
   output logic              full,
   output logic [PTR_W:0]    count,
   output logic              overflow,
   output logic              drain_valid,
   input  logic              drain_ready,
   output logic              drain_isbyte,
   output logic [ADDR_W-1:0] drain_addr,
   output logic [DATA_W-1:0] drain_data,
   input  logic [ADDR_W-1:0] lookup_addr,
   input  logic              lookup_isbyte,
   output logic              lookup_hit,
   output logic [DATA_W-1:0] lookup_data,
   output logic              lookup_conflict
);

   sb_entry_t        mem_q [DEPTH];
   logic [PTR_W-1:0] head_q, head_d;
   logic [PTR_W-1:0] tail_q, tail_d;
   logic [PTR_W:0]   count_q, count_d;
   logic             overflow_q, overflow_d;
   logic             push, pop;
   sb_entry_t        new_entry;

   assign full         = (count_q == (PTR_W+1)'(DEPTH));
   assign count        = count_q;
   assign overflow     = overflow_q;
   assign drain_valid  = (count_q != '0);
   assign drain_isbyte = mem_q[head_q].isbyte;
   assign drain_addr   = mem_q[head_q].addr;
   assign drain_data   = mem_q[head_q].data;

   assign new_entry = '{addr: store_addr, data: store_data, isbyte: store_isbyte};

   // Handshake decode and next-state for pointers, occupancy and the sticky overflow flag.
   always_comb begin
      pop        = drain_valid && drain_ready;
      push       = store_en && (!full || pop);
      head_d     = pop  ? head_q + PTR_W'(1) : head_q;
      tail_d     = push ? tail_q + PTR_W'(1) : tail_q;
      count_d    = count_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
      overflow_d = overflow_q | (store_en && !push);
   end

   // Control state; entry storage is left untouched by reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         head_q     <= '0;
         tail_q     <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         head_q     <= head_d;
         tail_q     <= tail_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
      end
   end

   // Entry storage write at the tail.
   always_ff @(posedge clk) begin
      if (!rst && push) begin
         mem_q[tail_q] <= new_entry;
      end
   end

   sb_forward_match #(
      .DEPTH (DEPTH),
      .PTR_W (PTR_W)
   ) u_fwd (
      .entries_i       (mem_q),
      .head_i          (head_q),
      .count_i         (count_q),
      .lookup_addr_i   (lookup_addr),
      .lookup_isbyte_i (lookup_isbyte),
      .hit_o           (lookup_hit),
      .data_o          (lookup_data),
      .conflict_o      (lookup_conflict)
   );

endmodule

// File: tb/tb_commit_store_buffer.sv
// Directed bench for commit_store_buffer with a queue scoreboard of expected drains.
module tb_commit_store_buffer;
   import commit_store_buffer_pkg::*;

   localparam int unsigned DEPTH = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic        store_en, store_isbyte;
   logic [19:0] store_addr;
   logic [31:0] store_data;
   logic        full;
   logic [3:0]  count;
   logic        overflow;
   logic        drain_valid, drain_ready, drain_isbyte;
   logic [19:0] drain_addr;
   logic [31:0] drain_data;
   logic [19:0] lookup_addr;
   logic        lookup_isbyte;
   logic        lookup_hit, lookup_conflict;
   logic [31:0] lookup_data;

   int          n_pass  = 0;
   int          n_total = 0;
   sb_entry_t   model_q [$];
   logic        ovf_m;

   always #5 clk = ~clk;

   commit_store_buffer dut (
      .clk             (clk),
      .rst             (rst),
      .store_en        (store_en),
      .store_isbyte    (store_isbyte),
      .store_addr      (store_addr),
      .store_data      (store_data),
      .full            (full),
      .count           (count),
      .overflow        (overflow),
      .drain_valid     (drain_valid),
      .drain_ready     (drain_ready),
      .drain_isbyte    (drain_isbyte),
      .drain_addr      (drain_addr),
      .drain_data      (drain_data),
      .lookup_addr     (lookup_addr),
      .lookup_isbyte   (lookup_isbyte),
      .lookup_hit      (lookup_hit),
      .lookup_data     (lookup_data),
      .lookup_conflict (lookup_conflict)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) begin
         n_pass++;
      end else begin
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic check_status(input string tag);
      chk({tag, " count"}, 32'(count), 32'(model_q.size()));
      chk({tag, " full"}, 32'(full), 32'(model_q.size() == DEPTH));
      chk({tag, " overflow"}, 32'(overflow), 32'(ovf_m));
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      model_q.delete();
      ovf_m = 1'b0;
   endtask

   // One clock: drive a store and/or drain handshake, score the drain, then check status.
   task automatic cycle(input logic en, input logic isb, input logic [19:0] a,
                        input logic [31:0] d, input logic rdy, input string tag);
      logic      do_pop, acc;
      sb_entry_t e;
      store_en = en; store_isbyte = isb; store_addr = a; store_data = d; drain_ready = rdy;
      #1;
      chk({tag, " drain_valid"}, 32'(drain_valid), 32'(model_q.size() != 0));
      do_pop = rdy && (model_q.size() != 0);
      if (do_pop) begin
         e = model_q.pop_front();
         chk({tag, " drain_addr"}, 32'(drain_addr), 32'(e.addr));
         chk({tag, " drain_data"}, drain_data, e.data);
         chk({tag, " drain_isbyte"}, 32'(drain_isbyte), 32'(e.isbyte));
      end
      acc = en && ((model_q.size() + (do_pop ? 1 : 0)) < DEPTH || do_pop);
      if (acc) model_q.push_back('{addr: a, data: d, isbyte: isb});
      else if (en) ovf_m = 1'b1;
      @(posedge clk); #1;
      store_en = 1'b0; drain_ready = 1'b0;
      check_status(tag);
   endtask

   task automatic look(input string tag, input logic [19:0] a, input logic isb,
                       input logic eh, input logic ec, input logic [31:0] ed);
      lookup_addr = a; lookup_isbyte = isb;
      #1;
      chk({tag, " hit"}, 32'(lookup_hit), 32'(eh));
      chk({tag, " conflict"}, 32'(lookup_conflict), 32'(ec));
      chk({tag, " data"}, lookup_data, ed);
   endtask

   initial begin
      rst = 1'b1; store_en = 1'b0; store_isbyte = 1'b0; store_addr = '0; store_data = '0;
      drain_ready = 1'b0; lookup_addr = '0; lookup_isbyte = 1'b0; ovf_m = 1'b0;
      @(posedge clk); #1;
      do_reset();

      // 1 reset state
      check_status("reset");
      chk("reset drain_valid", 32'(drain_valid), 32'd0);
      look("reset lookup", 20'h00100, 1'b0, 1'b0, 1'b0, 32'h0);
      cycle(1'b0, 1'b0, 20'h0, 32'h0, 1'b1, "pop_empty");

      // 2 order and drain
      cycle(1'b1, 1'b0, 20'h00100, 32'hDEADBEEF, 1'b0, "push_w");
      cycle(1'b1, 1'b1, 20'h00205, 32'h0000005A, 1'b0, "push_b");
      cycle(1'b0, 1'b0, 20'h0, 32'h0, 1'b1, "drain1");
      cycle(1'b0, 1'b0, 20'h0, 32'h0, 1'b1, "drain2");

      // 3 forwarding, youngest wins
      cycle(1'b1, 1'b0, 20'h00100, 32'h11223344, 1'b0, "fwd_push1");
      cycle(1'b1, 1'b0, 20'h00100, 32'hAABBCCDD, 1'b0, "fwd_push2");
      look("fwd word", 20'h00100, 1'b0, 1'b1, 1'b0, 32'hAABBCCDD);
      look("fwd byte", 20'h00102, 1'b1, 1'b1, 1'b0, 32'h000000BB);
      cycle(1'b0, 1'b0, 20'h0, 32'h0, 1'b1, "fwd_drain1");
      cycle(1'b0, 1'b0, 20'h0, 32'h0, 1'b1, "fwd_drain2");

      // 4 byte entry against word and byte loads
      cycle(1'b1, 1'b1, 20'h00101, 32'h00000077, 1'b0, "cf_push");
      look("cf word", 20'h00100, 1'b0, 1'b0, 1'b1, 32'h0);
      look("cf byte other lane", 20'h00103, 1'b1, 1'b0, 1'b0, 32'h0);
      look("cf byte same lane", 20'h00101, 1'b1, 1'b1, 1'b0, 32'h00000077);
      cycle(1'b0, 1'b0, 20'h0, 32'h0, 1'b1, "cf_drain");

      // 5 fill, push+pop while full, overflow, drain across the wrap
      for (int i = 0; i < DEPTH; i++)
         cycle(1'b1, 1'b0, 20'h00400 + 20'(i * 4), 32'hC0DE0000 + 32'(i), 1'b0, "fill");
      cycle(1'b1, 1'b0, 20'h00480, 32'hC0DE0080, 1'b1, "full_pushpop");
      cycle(1'b1, 1'b0, 20'h00500, 32'hBAD00500, 1'b0, "full_drop");
      look("dropped miss", 20'h00500, 1'b0, 1'b0, 1'b0, 32'h0);
      look("wrapped hit", 20'h00480, 1'b0, 1'b1, 1'b0, 32'hC0DE0080);
      for (int i = 0; i < DEPTH; i++)
         cycle(1'b0, 1'b0, 20'h0, 32'h0, 1'b1, "wrap_drain");

      // 6 reset with entries held
      cycle(1'b1, 1'b0, 20'h00600, 32'h66666666, 1'b0, "r_push1");
      cycle(1'b1, 1'b1, 20'h00605, 32'h00000055, 1'b0, "r_push2");
      cycle(1'b1, 1'b0, 20'h00608, 32'h88888888, 1'b0, "r_push3");
      do_reset();
      check_status("mid_reset");
      chk("mid_reset drain_valid", 32'(drain_valid), 32'd0);
      look("mid_reset l1", 20'h00600, 1'b0, 1'b0, 1'b0, 32'h0);
      look("mid_reset l2", 20'h00605, 1'b1, 1'b0, 1'b0, 32'h0);
      look("mid_reset l3", 20'h00608, 1'b0, 1'b0, 1'b0, 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
